// File: rtl/cache_mem_bridge.sv
// rtl/cache_mem_bridge.sv - converts 128-bit cache line fill/write-back requests into 4 x 32-bit bus beats
package cache;
  typedef struct packed {
    logic         valid;
    logic         rw;
    logic [31:0]  addr;
    logic [127:0] data;
  } mem_req_t;

  typedef struct packed {
    logic         ready;
    logic [127:0] data;
  } mem_resp_t;
endpackage

module cache_mem_bridge (
  input  logic             clk,
  input  logic             reset,
  input  cache::mem_req_t  mem_req,
  output cache::mem_resp_t mem_resp,
  output logic             bus_req_valid,
  input  logic             bus_req_ready,
  output logic             bus_req_we,
  output logic [31:0]      bus_req_addr,
  output logic [31:0]      bus_req_wdata,
  input  logic             bus_rsp_valid,
  input  logic [31:0]      bus_rsp_rdata,
  output logic             err
);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_base;
  logic [3:0][31:0]  r_wline;
  logic [3:0][31:0]  r_rline;
  logic [2:0]        r_iss;
  logic [2:0]        r_rcv;
  logic              r_valid;
  logic              r_we;
  logic              r_err;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;

  logic              w_acc;
  logic              w_hs;
  logic              w_rsp_ok;
  logic [2:0]        w_iss_nxt;
  logic              w_unused_addr_lo;

  // Response eligibility uses the post-acceptance issue count so a zero-latency beat counts.
  always_comb begin
    w_acc     = mem_req.valid && ((r_state == S_IDLE) || (r_state == S_DONE));
    w_hs      = r_valid && bus_req_ready;
    w_iss_nxt = r_iss + {2'b00, w_hs};
    w_rsp_ok  = bus_rsp_valid && (r_state == S_RD) && (r_rcv < w_iss_nxt);
  end

  assign w_unused_addr_lo = &{1'b0, mem_req.addr[3:0]};

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_acc) w_state_nxt = mem_req.rw ? S_WR : S_RD;
      S_WR:   if (w_hs && (w_iss_nxt == 3'd4)) w_state_nxt = S_DONE;
      S_RD:   if (w_rsp_ok && (r_rcv == 3'd3)) w_state_nxt = S_DONE;
      S_DONE: begin
        if (w_acc) w_state_nxt = mem_req.rw ? S_WR : S_RD;
        else       w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_base  <= '0;
      r_wline <= '0;
      r_rline <= '0;
      r_iss   <= '0;
      r_rcv   <= '0;
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      if (w_acc) begin
        r_base  <= {mem_req.addr[31:4], 4'b0000};
        r_wline <= mem_req.data;
        r_iss   <= '0;
        r_rcv   <= '0;
        r_valid <= 1'b1;
        r_we    <= mem_req.rw;
        r_addr  <= {mem_req.addr[31:4], 4'b0000};
        r_wdata <= mem_req.data[31:0];
      end else if (w_hs) begin
        r_iss <= w_iss_nxt;
        if (w_iss_nxt == 3'd4) begin
          r_valid <= 1'b0;
        end else begin
          r_addr  <= r_base + {28'd0, w_iss_nxt[1:0], 2'b00};
          r_wdata <= r_wline[w_iss_nxt[1:0]];
        end
      end
      if (w_rsp_ok) begin
        r_rline[r_rcv[1:0]] <= bus_rsp_rdata;
        r_rcv               <= r_rcv + 3'd1;
      end
      if (bus_rsp_valid && !w_rsp_ok) r_err <= 1'b1;
    end
  end

  assign bus_req_valid = r_valid;
  assign bus_req_we    = r_we;
  assign bus_req_addr  = r_addr;
  assign bus_req_wdata = r_wdata;
  assign err           = r_err;
  assign mem_resp      = '{ready: (r_state == S_DONE), data: r_rline};

endmodule

// File: tb/tb_cache_mem_bridge.sv
// tb/tb_cache_mem_bridge.sv - directed self-checking bench for cache_mem_bridge
module tb_cache_mem_bridge;
  logic             clk = 1'b0;
  logic             reset;
  cache::mem_req_t  mem_req;
  cache::mem_resp_t mem_resp;
  logic             bus_req_valid;
  logic             bus_req_ready;
  logic             bus_req_we;
  logic [31:0]      bus_req_addr;
  logic [31:0]      bus_req_wdata;
  logic             bus_rsp_valid;
  logic [31:0]      bus_rsp_rdata;
  logic             err;

  int errors = 0;
  int checks = 0;

  cache_mem_bridge dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_resp(mem_resp),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we),
    .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    mem_req = '0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rsp_rdata = '0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic issue(input logic rw, input logic [31:0] addr, input logic [127:0] data);
    mem_req.valid = 1'b1;
    mem_req.rw    = rw;
    mem_req.addr  = addr;
    mem_req.data  = data;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (bus_req_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus_req_valid); end
    checks++; if (bus_req_we !== 1'b0) begin errors++; $display("FAIL rst_we got %b exp 0", bus_req_we); end
    checks++; if (bus_req_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", bus_req_addr); end
    checks++; if (bus_req_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h exp 0", bus_req_wdata); end
    checks++; if (mem_resp.ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", mem_resp.ready); end
    checks++; if (mem_resp.data !== 128'h0) begin errors++; $display("FAIL rst_data got %h exp 0", mem_resp.data); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
  endtask

  task automatic test_fill;
    int q[$];
    int acc_n = 0, rsp_n = 0, pulses = 0, done_at = -1;
    tick;
    issue(1'b0, 32'h0000_1234, '0);
    bus_req_ready = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick;
      mem_req.valid = 1'b0;
      bus_rsp_valid = 1'b0;
      if (bus_req_valid && bus_req_ready) begin
        checks++; if (bus_req_addr !== 32'h1230 + 32'(4 * acc_n)) begin errors++; $display("FAIL fill_addr got %h exp %h", bus_req_addr, 32'h1230 + 32'(4 * acc_n)); end
        checks++; if (bus_req_we !== 1'b0) begin errors++; $display("FAIL fill_we got %b exp 0", bus_req_we); end
        q.push_back(t);
        acc_n++;
      end
      if (q.size() > 0 && q[0] + 2 == t) begin
        void'(q.pop_front());
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 32'hA0 + 32'(rsp_n);
        rsp_n++;
      end
      if (mem_resp.ready) begin pulses++; done_at = t; end
    end
    checks++; if (acc_n !== 4) begin errors++; $display("FAIL fill_beats got %0d exp 4", acc_n); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL fill_pulses got %0d exp 1", pulses); end
    checks++; if (done_at !== 7) begin errors++; $display("FAIL fill_done_cycle got %0d exp 7", done_at); end
    checks++; if (mem_resp.data !== 128'h000000A3_000000A2_000000A1_000000A0) begin errors++; $display("FAIL fill_data got %h exp 000000a3000000a2000000a1000000a0", mem_resp.data); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL fill_err got %b exp 0", err); end
  endtask

  task automatic test_write_toggle;
    int acc_n = 0, pulses = 0, done_at = -1, unstable = 0;
    logic prev_pending = 1'b0;
    logic [31:0] prev_addr = '0, prev_wdata = '0;
    tick;
    issue(1'b1, 32'h8000_00F0, 128'h44444444_33333333_22222222_11111111);
    bus_req_ready = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick;
      mem_req.valid = 1'b0;
      bus_req_ready = (t % 2 == 1);
      if (prev_pending && bus_req_valid && (bus_req_addr !== prev_addr || bus_req_wdata !== prev_wdata)) unstable++;
      prev_pending = bus_req_valid && !bus_req_ready;
      prev_addr = bus_req_addr;
      prev_wdata = bus_req_wdata;
      if (bus_req_valid && bus_req_ready) begin
        checks++; if (bus_req_addr !== 32'h8000_00F0 + 32'(4 * acc_n)) begin errors++; $display("FAIL wb_addr got %h exp %h", bus_req_addr, 32'h8000_00F0 + 32'(4 * acc_n)); end
        checks++; if (bus_req_wdata !== 32'h11111111 * 32'(acc_n + 1)) begin errors++; $display("FAIL wb_wdata got %h exp %h", bus_req_wdata, 32'h11111111 * 32'(acc_n + 1)); end
        checks++; if (bus_req_we !== 1'b1) begin errors++; $display("FAIL wb_we got %b exp 1", bus_req_we); end
        acc_n++;
      end
      if (mem_resp.ready) begin pulses++; done_at = t; end
    end
    checks++; if (acc_n !== 4) begin errors++; $display("FAIL wb_beats got %0d exp 4", acc_n); end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL wb_hold got %0d unstable cycles exp 0", unstable); end
    checks++; if (pulses !== 1 || done_at !== 8) begin errors++; $display("FAIL wb_done got pulses=%0d cycle=%0d exp 1 at 8", pulses, done_at); end
    checks++; if (mem_resp.data !== 128'h000000A3_000000A2_000000A1_000000A0) begin errors++; $display("FAIL wb_data_kept got %h exp previous fill line", mem_resp.data); end
  endtask

  task automatic test_back_to_back;
    int q[$];
    int wr_n = 0, rd_n = 0, rsp_n = 0, pulses = 0, chain_t = -1, first_rd = -1, done_at = -1;
    tick;
    issue(1'b1, 32'h0000_0100, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
    bus_req_ready = 1'b1;
    for (int t = 1; t <= 14; t++) begin
      tick;
      mem_req.valid = 1'b0;
      bus_rsp_valid = 1'b0;
      if (mem_resp.ready) begin
        pulses++;
        if (chain_t < 0) begin
          chain_t = t;
          issue(1'b0, 32'h0000_2008, '0);
        end else begin
          done_at = t;
        end
      end
      if (bus_req_valid && bus_req_ready) begin
        if (bus_req_we) wr_n++;
        else begin
          if (first_rd < 0) first_rd = t;
          checks++; if (bus_req_addr !== 32'h2000 + 32'(4 * rd_n)) begin errors++; $display("FAIL chain_addr got %h exp %h", bus_req_addr, 32'h2000 + 32'(4 * rd_n)); end
          rd_n++;
          q.push_back(t);
        end
      end
      if (q.size() > 0 && q[0] == t) begin
        void'(q.pop_front());
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 32'hB0 + 32'(rsp_n);
        rsp_n++;
      end
    end
    checks++; if (wr_n !== 4 || chain_t !== 5) begin errors++; $display("FAIL chain_wb got beats=%0d done=%0d exp 4 at 5", wr_n, chain_t); end
    checks++; if (first_rd !== 6) begin errors++; $display("FAIL chain_first_read got %0d exp 6", first_rd); end
    checks++; if (pulses !== 2 || done_at !== 10) begin errors++; $display("FAIL chain_fill_done got pulses=%0d cycle=%0d exp 2 at 10", pulses, done_at); end
    checks++; if (mem_resp.data !== 128'h000000B3_000000B2_000000B1_000000B0) begin errors++; $display("FAIL chain_data got %h exp 000000b3000000b2000000b1000000b0", mem_resp.data); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL chain_err got %b exp 0", err); end
  endtask

  task automatic test_err_idle;
    tick;
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = 32'hDEAD_BEEF;
    tick;
    bus_rsp_valid = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_idle got %b exp 1", err); end
    checks++; if (mem_resp.data !== 128'h000000B3_000000B2_000000B1_000000B0) begin errors++; $display("FAIL err_idle_data got %h exp unchanged", mem_resp.data); end
    repeat (3) tick;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", err); end
  endtask

  task automatic test_reset_mid;
    int bad = 0;
    do_reset;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_clears_err got %b exp 0", err); end
    issue(1'b0, 32'h0000_3000, '0);
    bus_req_ready = 1'b1;
    tick;
    mem_req.valid = 1'b0;
    tick;
    bus_req_ready = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++; if (bus_req_valid !== 1'b0 || bus_req_we !== 1'b0 || bus_req_addr !== 32'h0 || bus_req_wdata !== 32'h0)
      begin errors++; $display("FAIL midrst_bus got v=%b we=%b a=%h d=%h exp all 0", bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata); end
    checks++; if (mem_resp.ready !== 1'b0 || mem_resp.data !== 128'h0 || err !== 1'b0)
      begin errors++; $display("FAIL midrst_resp got rdy=%b data=%h err=%b exp 0", mem_resp.ready, mem_resp.data, err); end
    for (int t = 0; t < 4; t++) begin
      bus_rsp_valid = (t == 1);
      bus_rsp_rdata = 32'h5555_0000;
      tick;
      if (mem_resp.ready || bus_req_valid) bad++;
    end
    bus_rsp_valid = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL midrst_quiet got %0d active cycles exp 0", bad); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL midrst_late_rsp_err got %b exp 1", err); end
  endtask

  task automatic test_stall;
    int q[$];
    int acc_n = 0, rsp_n = 0, pulses = 0, done_at = -1, unstable = 0;
    do_reset;
    issue(1'b0, 32'h0000_004C, '0);
    for (int t = 1; t <= 20; t++) begin
      tick;
      mem_req.valid = 1'b0;
      bus_rsp_valid = 1'b0;
      bus_req_ready = (t >= 11);
      if (t <= 10 && (bus_req_valid !== 1'b1 || bus_req_addr !== 32'h40)) unstable++;
      if (t == 5) begin bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hEE; end
      if (t == 6) begin
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL stall_early_rsp_err got %b exp 1", err); end
      end
      if (bus_req_valid && bus_req_ready) begin q.push_back(t); acc_n++; end
      if (q.size() > 0 && q[0] + 1 == t) begin
        void'(q.pop_front());
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 32'hC0 + 32'(rsp_n);
        rsp_n++;
      end
      if (mem_resp.ready) begin pulses++; done_at = t; end
    end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL stall_hold got %0d bad cycles exp 0", unstable); end
    checks++; if (acc_n !== 4) begin errors++; $display("FAIL stall_beats got %0d exp 4", acc_n); end
    checks++; if (pulses !== 1 || done_at !== 16) begin errors++; $display("FAIL stall_done got pulses=%0d cycle=%0d exp 1 at 16", pulses, done_at); end
    checks++; if (mem_resp.data !== 128'h000000C3_000000C2_000000C1_000000C0) begin errors++; $display("FAIL stall_data got %h exp 000000c3000000c2000000c1000000c0", mem_resp.data); end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_write_toggle;
    test_back_to_back;
    test_err_idle;
    test_reset_mid;
    test_stall;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
